// File: rtl/sext_pipe_if.sv
// sext_pipe_if: valid/ready handshake bundle for the sext_pipe extender.
// Input beat (field, selector, mode bits) and output beat (result, flag).
interface sext_pipe_if #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = $clog2(DATA_W)
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [SEL_W-1:0]  in_msb;
    logic              in_zext;
    logic              in_lshf;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_ovf;

    modport master (
        output in_valid, in_data, in_msb, in_zext, in_lshf, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_msb, in_zext, in_lshf, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/sext_pipe.sv
// sext_pipe: two-stage pipelined sign/zero extender with optional LSHF1.
// Stage 1 extends from the selected MSB, stage 2 shifts and flags overflow.
module sext_pipe #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = $clog2(DATA_W)
) (
    input logic clk,
    input logic rst_n,
    sext_pipe_if.slave bus
);
    localparam logic [SEL_W-1:0] MSB_MAX = SEL_W'(DATA_W - 1);

    logic              s1_valid;
    logic [DATA_W-1:0] s1_ext;
    logic              s1_lshf;
    logic              s1_zext;

    logic              s2_valid;
    logic [DATA_W-1:0] s2_data;
    logic              s2_ovf;

    logic              s1_adv;
    logic              in_fire;
    logic [SEL_W-1:0]  msb_c;
    logic              fill;
    logic [DATA_W-1:0] ext_c;
    logic [DATA_W-1:0] shf_c;
    logic              ovf_c;

    assign s1_adv      = s1_valid & (!s2_valid | bus.out_ready);
    assign bus.in_ready = !s1_valid | !s2_valid | bus.out_ready;
    assign in_fire     = bus.in_valid & bus.in_ready;

    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data;
    assign bus.out_ovf   = s2_ovf;

    // Clamp the selector and replicate the fill bit above the field MSB.
    always_comb begin
        msb_c = (bus.in_msb > MSB_MAX) ? MSB_MAX : bus.in_msb;
        fill  = bus.in_zext ? 1'b0 : bus.in_data[msb_c];
        ext_c = '0;
        for (int i = 0; i < DATA_W; i++) begin
            ext_c[i] = (SEL_W'(i) <= msb_c) ? bus.in_data[i] : fill;
        end
    end

    // Word-offset shift; overflow only meaningful for signed fields.
    always_comb begin
        shf_c = s1_ext;
        ovf_c = 1'b0;
        if (s1_lshf) begin
            shf_c = {s1_ext[DATA_W-2:0], 1'b0};
            ovf_c = !s1_zext & (s1_ext[DATA_W-1] ^ s1_ext[DATA_W-2]);
        end
    end

    // Stage 1 register: loads when empty or draining this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_ext   <= '0;
            s1_lshf  <= 1'b0;
            s1_zext  <= 1'b0;
        end else begin
            s1_valid <= in_fire | (s1_valid & !s1_adv);
            if (in_fire) begin
                s1_ext  <= ext_c;
                s1_lshf <= bus.in_lshf;
                s1_zext <= bus.in_zext;
            end
        end
    end

    // Stage 2 register: holds its beat stable until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_ovf   <= 1'b0;
        end else begin
            s2_valid <= s1_adv | (s2_valid & !bus.out_ready);
            if (s1_adv) begin
                s2_data <= shf_c;
                s2_ovf  <= ovf_c;
            end
        end
    end
endmodule

// File: tb/tb_sext_pipe.sv
// tb_sext_pipe: scoreboard bench for sext_pipe at DATA_W=16 and DATA_W=12.
// Driver pushes hand-computed results; monitors pop and compare on output.
module tb_sext_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sext_pipe_if #(.DATA_W(16)) b16 ();
    sext_pipe_if #(.DATA_W(12)) b12 ();

    sext_pipe #(.DATA_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));
    sext_pipe #(.DATA_W(12)) dut12 (.clk(clk), .rst_n(rst_n), .bus(b12.slave));

    typedef struct {
        logic [15:0] d;
        logic        ovf;
    } exp_t;

    exp_t q16[$];
    exp_t q12[$];
    int total = 0;
    int passed = 0;
    int accepted = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // 16-bit monitor: compares every presented beat, pops on transfer.
    always @(negedge clk) begin
        if (rst_n && b16.out_valid) begin
            if (q16.size() == 0) begin
                total++;
                $display("FAIL m16_unexpected: got %0h expected no beat", b16.out_data);
            end else begin
                chk("m16_data", 64'(b16.out_data), 64'(q16[0].d));
                chk("m16_ovf", 64'(b16.out_ovf), 64'(q16[0].ovf));
                if (b16.out_ready) void'(q16.pop_front());
            end
        end
    end

    // 12-bit monitor for the clamp cases.
    always @(negedge clk) begin
        if (rst_n && b12.out_valid) begin
            if (q12.size() == 0) begin
                total++;
                $display("FAIL m12_unexpected: got %0h expected no beat", b12.out_data);
            end else begin
                chk("m12_data", 64'(b12.out_data), 64'(q12[0].d[11:0]));
                chk("m12_ovf", 64'(b12.out_ovf), 64'(q12[0].ovf));
                if (b12.out_ready) void'(q12.pop_front());
            end
        end
    end

    task automatic send16(input logic [15:0] d, input logic [3:0] m,
                          input logic z, input logic l,
                          input logic [15:0] ed, input logic eo);
        int n;
        b16.in_valid = 1'b1;
        b16.in_data  = d;
        b16.in_msb   = m;
        b16.in_zext  = z;
        b16.in_lshf  = l;
        n = 0;
        @(negedge clk);
        while (!b16.in_ready) begin
            n++;
            if (n > 50) begin
                total++;
                $display("FAIL send16_timeout: got in_ready=0 expected accept of %0h", d);
                b16.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        q16.push_back('{ed, eo});
        accepted++;
        #1 b16.in_valid = 1'b0;
    endtask

    task automatic send12(input logic [11:0] d, input logic [3:0] m,
                          input logic z, input logic l,
                          input logic [11:0] ed, input logic eo);
        int n;
        b12.in_valid = 1'b1;
        b12.in_data  = d;
        b12.in_msb   = m;
        b12.in_zext  = z;
        b12.in_lshf  = l;
        n = 0;
        @(negedge clk);
        while (!b12.in_ready) begin
            n++;
            if (n > 50) begin
                total++;
                $display("FAIL send12_timeout: got in_ready=0 expected accept of %0h", d);
                b12.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        q12.push_back('{{4'h0, ed}, eo});
        #1 b12.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q16.size() != 0 || q12.size() != 0) && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, 64'(q16.size() + q12.size()), 64'd0);
    endtask

    initial begin
        int c0;
        b16.in_valid = 1'b0; b16.in_data = '0; b16.in_msb = '0;
        b16.in_zext = 1'b0; b16.in_lshf = 1'b0; b16.out_ready = 1'b1;
        b12.in_valid = 1'b0; b12.in_data = '0; b12.in_msb = '0;
        b12.in_zext = 1'b0; b12.in_lshf = 1'b0; b12.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(b16.out_valid), 64'd0);
        chk("rst_out_data", 64'(b16.out_data), 64'd0);
        chk("rst_in_ready", 64'(b16.in_ready), 64'd1);
        chk("rst12_out_valid", 64'(b12.out_valid), 64'd0);
        rst_n = 1'b1;

        // Basic sign/zero extend and PCoffset9 shift.
        send16(16'h0013, 4'd4, 1'b0, 1'b0, 16'hFFF3, 1'b0);
        send16(16'h0013, 4'd4, 1'b1, 1'b0, 16'h0013, 1'b0);
        send16(16'h01FF, 4'd8, 1'b0, 1'b1, 16'hFFFE, 1'b0);
        send16(16'h4000, 4'd15, 1'b0, 1'b1, 16'h8000, 1'b1);
        drain("drain_basic");

        // Back-to-back stream of 8 mixed beats.
        c0 = cyc;
        send16(16'h00AB, 4'd7, 1'b0, 1'b0, 16'hFFAB, 1'b0);
        send16(16'h00AB, 4'd7, 1'b1, 1'b1, 16'h0156, 1'b0);
        send16(16'h0030, 4'd5, 1'b0, 1'b1, 16'hFFE0, 1'b0);
        send16(16'h7FFF, 4'd15, 1'b0, 1'b1, 16'hFFFE, 1'b1);
        send16(16'hFFFF, 4'd0, 1'b0, 1'b0, 16'hFFFF, 1'b0);
        send16(16'hFFFE, 4'd0, 1'b0, 1'b0, 16'h0000, 1'b0);
        send16(16'h1234, 4'd10, 1'b1, 1'b0, 16'h0234, 1'b0);
        send16(16'h8421, 4'd15, 1'b1, 1'b1, 16'h0842, 1'b0);
        chk("stream_cycles", 64'(cyc - c0), 64'd8);
        drain("drain_stream");

        // Backpressure: only two beats fit while the consumer stalls.
        b16.out_ready = 1'b0;
        accepted = 0;
        fork
            begin
                send16(16'h000F, 4'd3, 1'b0, 1'b0, 16'hFFFF, 1'b0);
                send16(16'h0007, 4'd3, 1'b0, 1'b0, 16'h0007, 1'b0);
                send16(16'h0100, 4'd8, 1'b0, 1'b1, 16'hFE00, 1'b0);
                send16(16'h0002, 4'd1, 1'b1, 1'b1, 16'h0004, 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                chk("bp_accepted", 64'(accepted), 64'd2);
                chk("bp_in_ready", 64'(b16.in_ready), 64'd0);
                chk("bp_out_valid", 64'(b16.out_valid), 64'd1);
                b16.out_ready = 1'b1;
            end
        join
        drain("drain_bp");
        chk("bp_total", 64'(accepted), 64'd4);

        // Selector clamp at DATA_W=12.
        send12(12'h800, 4'd15, 1'b0, 1'b0, 12'h800, 1'b0);
        send12(12'h800, 4'd11, 1'b0, 1'b0, 12'h800, 1'b0);
        send12(12'h800, 4'd13, 1'b1, 1'b1, 12'h000, 1'b0);
        send12(12'h800, 4'd14, 1'b0, 1'b1, 12'h000, 1'b1);
        drain("drain_clamp");

        // Reset with two beats in flight.
        b16.out_ready = 1'b0;
        send16(16'h0001, 4'd3, 1'b0, 1'b0, 16'h0001, 1'b0);
        send16(16'h0002, 4'd3, 1'b0, 1'b0, 16'h0002, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(b16.out_valid), 64'd0);
        chk("mid_rst_out_data", 64'(b16.out_data), 64'd0);
        chk("mid_rst_in_ready", 64'(b16.in_ready), 64'd1);
        q16.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        b16.out_ready = 1'b1;
        send16(16'h0005, 4'd2, 1'b0, 1'b1, 16'hFFFA, 1'b0);
        drain("drain_after_rst");
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
